// File: rtl/lsu_pkg.sv
// Purpose: shared encodings for the load/store unit (sizes, FSM states, latched request).
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package lsu_pkg;

    // Word-address width of the 128-word data memory.
    localparam int LSU_ADDR_W = 7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4,
        RESP = 3'd5
    } lsu_state_e;

    // Request fields held for the whole operation (word address is kept separately
    // because its width follows the ADDR_W parameter).
    typedef struct packed {
        logic       write;
        logic [1:0] size;
        logic       sgn;
        logic [1:0] offset;
        logic       mis;
    } lsu_req_t;

    // Size 3 is always rejected; halves need an even offset, words offset 0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SZ_HALF) && offset[0]) ||
               ((size == SZ_WORD) && (offset != 2'd0)) ||
               (size == 2'd3);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Purpose: little-endian lane extraction (with sign/zero extension) and sub-word store merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: word_i (memory word), wdata_i (right-justified store data), offset_i/size_i/sign_i
//        (access shape), rdata_o (extended load value), merged_o (word with store lane replaced).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic [31:0] rdata_o,
    output logic [31:0] merged_o
);

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] offset,
                                            input logic [1:0] size, input logic sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {offset, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                          input logic [1:0] offset, input logic [1:0] size);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00ff << {offset, 3'b000};
                data = {24'b0, wdata[7:0]} << {offset, 3'b000};
            end
            SZ_HALF: begin
                mask = 32'h0000_ffff << {offset, 3'b000};
                data = {16'b0, wdata[15:0]} << {offset, 3'b000};
            end
            default: begin
                mask = 32'hffff_ffff;
                data = wdata;
            end
        endcase
        return (old_word & ~mask) | (data & mask);
    endfunction

    assign rdata_o  = extract(word_i, offset_i, size_i, sign_i);
    assign merged_o = merge(word_i, wdata_i, offset_i, size_i);

endmodule

// File: rtl/load_store_unit.sv
// Purpose: byte-addressed load/store front end for a word-only data memory (RMW for sub-word stores).
// Latency: acceptance to resp_valid: word store 2, load 3, sub-word store 4, misaligned 2 cycles.
// Backpressure: req_ready only in IDLE (one request outstanding); resp_* is a pulse with no backpressure.
// Ports: req_* request channel, resp_* one-cycle response, mem_* word port to the data memory
//        (mem_data_out valid the cycle after a mem_read cycle).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out
);

    lsu_state_e        state_q, state_d;
    lsu_req_t          req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // Holds the full store word: req_wdata for word stores, the merged word for RMW.
    logic [DATA_W-1:0] wbuf_q, wbuf_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [31:0] lane_rdata;
    logic [31:0] lane_merged;

    lsu_lane_align u_lane_align (
        .word_i   (mem_data_out),
        .wdata_i  (wbuf_q),
        .offset_i (req_q.offset),
        .size_i   (req_q.size),
        .sign_i   (req_q.sgn),
        .rdata_o  (lane_rdata),
        .merged_o (lane_merged)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.write  = req_write;
                    req_d.size   = req_size;
                    req_d.sgn    = req_signed;
                    req_d.offset = req_addr[1:0];
                    req_d.mis    = is_misaligned(req_size, req_addr[1:0]);
                    addr_d       = req_addr[ADDR_W+1:2];
                    wbuf_d       = req_wdata;
                    // Cleared so stores and errors respond with zero data.
                    rdata_d      = '0;
                    if (req_d.mis) begin
                        state_d = ERR;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (req_q.write) begin
                    wbuf_d  = lane_merged;
                    state_d = WR;
                end else begin
                    rdata_d = lane_rdata;
                    state_d = RESP;
                end
            end
            WR:      state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state only. reset_n gates req_ready so the
    // unit never advertises acceptance while held in reset.
    always_comb begin
        req_ready       = (state_q == IDLE) && reset_n;
        mem_read        = (state_q == RD) || (state_q == CAP);
        mem_write       = (state_q == WR);
        mem_address     = (mem_read || mem_write) ? addr_q : '0;
        mem_write_data  = mem_write ? wbuf_q : '0;
        resp_valid      = (state_q == RESP);
        resp_rdata      = resp_valid ? rdata_q : '0;
        resp_misaligned = resp_valid && req_q.mis;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Purpose: scoreboard bench for load_store_unit with a behavioural 128-word memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic [6:0]  mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_data_out;

    load_store_unit #(.ADDR_W(7), .DATA_W(32)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_size        (req_size),
        .req_signed      (req_signed),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_data_out    (mem_data_out)
    );

    always #5 clock = ~clock;

    // Behavioural data memory plus a preload port for the bench.
    logic [31:0] mem [128];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write) mem[mem_address] <= mem_write_data;
        if (mem_read) mem_data_out <= mem[mem_address];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          t_acc;
        string       name;
    } exp_t;
    typedef struct {
        logic [6:0]  addr;
        logic [31:0] data;
        string       name;
    } wexp_t;

    exp_t  sbq[$];
    wexp_t wq[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rd_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got event want none", nm);
    endtask

    // Monitor: pops expected responses / writes whenever the DUT presents them.
    always @(negedge clock) begin
        exp_t  e;
        wexp_t w;
        if (mem_read) rd_cnt <= rd_cnt + 1;
        if (resp_valid) begin
            if (sbq.size() == 0) flag("unexpected_resp");
            else begin
                e = sbq.pop_front();
                chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                chk({e.name, "_mis"}, {31'b0, resp_misaligned}, {31'b0, e.mis});
                chk({e.name, "_lat"}, cyc - e.t_acc, e.lat);
            end
        end
        if (mem_write) begin
            if (wq.size() == 0) flag("unexpected_write");
            else begin
                w = wq.pop_front();
                chk({w.name, "_waddr"}, {25'b0, mem_address}, {25'b0, w.addr});
                chk({w.name, "_wdata"}, mem_write_data, w.data);
            end
        end
    end

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    // Drives one request, waits (bounded) for acceptance and records the expectation.
    task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [8:0] a, input logic [31:0] wd, input logic [31:0] er,
                         input logic em, input int lat, input logic push_resp,
                         input logic push_wr, input logic [31:0] ew);
        exp_t  e;
        wexp_t x;
        int    n;
        n = 0;
        @(negedge clock);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            flag({nm, "_accept_timeout"});
            req_valid = 1'b0;
            return;
        end
        if (push_resp) begin
            e.rdata = er; e.mis = em; e.lat = lat; e.t_acc = cyc; e.name = nm;
            sbq.push_back(e);
        end
        if (push_wr) begin
            x.addr = a[8:2]; x.data = ew; x.name = nm;
            wq.push_back(x);
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || wq.size() != 0) && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0 || wq.size() != 0) begin
            flag("drain_timeout");
            sbq.delete();
            wq.delete();
        end
        @(negedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   r0;
        exp_t e;
        int   n;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_mem_ctl", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", {25'b0, mem_address}, 32'd0);
        chk("rst_resp", {31'b0, resp_valid}, 32'd0);
        reset_n = 1'b1;
        #1 chk("rel_ready", {31'b0, req_ready}, 32'd1);

        preload(7'd4, 32'hCAFE_F00D);
        preload(7'd5, 32'h1122_3344);
        preload(7'd7, 32'h0000_0000);
        preload(7'd9, 32'h0000_0000);

        // Word store then load
        issue("sw100", 1, 2'd2, 0, 9'h190, 32'h0000_0003, 32'h0, 0, 2, 1, 1, 32'h0000_0003);
        issue("lw100", 0, 2'd2, 0, 9'h190, 32'h0, 32'h0000_0003, 0, 3, 1, 0, 32'h0);
        drain();

        // Byte RMW and byte loads
        issue("sb016", 1, 2'd0, 0, 9'h016, 32'hFFFF_FFAB, 32'h0, 0, 4, 1, 1, 32'h11AB_3344);
        issue("lbu016", 0, 2'd0, 0, 9'h016, 32'h0, 32'h0000_00AB, 0, 3, 1, 0, 32'h0);
        issue("lb016", 0, 2'd0, 1, 9'h016, 32'h0, 32'hFFFF_FFAB, 0, 3, 1, 0, 32'h0);
        drain();

        // Halfword
        issue("sh01e", 1, 2'd1, 0, 9'h01E, 32'h0000_8001, 32'h0, 0, 4, 1, 1, 32'h8001_0000);
        issue("lh01e", 0, 2'd1, 1, 9'h01E, 32'h0, 32'hFFFF_8001, 0, 3, 1, 0, 32'h0);
        issue("lhu01e", 0, 2'd1, 0, 9'h01E, 32'h0, 32'h0000_8001, 0, 3, 1, 0, 32'h0);
        issue("lh01c", 0, 2'd1, 1, 9'h01C, 32'h0, 32'h0000_0000, 0, 3, 1, 0, 32'h0);
        drain();

        // Misalignment: no memory reads or writes, memory unchanged
        r0 = rd_cnt;
        issue("lw191", 0, 2'd2, 0, 9'h191, 32'h0, 32'h0, 1, 2, 1, 0, 32'h0);
        issue("sh013", 1, 2'd1, 0, 9'h013, 32'h0000_BEEF, 32'h0, 1, 2, 1, 0, 32'h0);
        issue("sz3", 1, 2'd3, 0, 9'h010, 32'h1234_5678, 32'h0, 1, 2, 1, 0, 32'h0);
        drain();
        chk("mis_no_reads", rd_cnt - r0, 32'd0);
        chk("mis_mem100", mem[100], 32'h0000_0003);
        chk("mis_mem4", mem[4], 32'hCAFE_F00D);

        // Handshake: valid held high, wdata changing while busy
        @(negedge clock);
        req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 9'h025; req_wdata = 32'h0000_005A;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("hs_first_ready", {31'b0, req_ready}, 32'd1);
        e.rdata = 32'h0; e.mis = 0; e.lat = 4; e.t_acc = cyc; e.name = "hs_sb";
        sbq.push_back(e);
        wq.push_back('{addr: 7'd9, data: 32'h0000_5A00, name: "hs_sb"});
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk($sformatf("hs_busy_ready%0d", i), {31'b0, req_ready}, 32'd0);
            req_wdata = 32'hFFFF_FF00 | i;
        end
        @(negedge clock);
        chk("hs_idle_ready", {31'b0, req_ready}, 32'd1);
        req_write = 0; req_size = 2'd0; req_signed = 0; req_addr = 9'h025;
        e.rdata = 32'h0000_005A; e.mis = 0; e.lat = 3; e.t_acc = cyc; e.name = "hs_lbu";
        sbq.push_back(e);
        @(posedge clock);
        #1 req_valid = 1'b0;
        drain();

        // Reset abort during CAP of a byte RMW
        preload(7'd5, 32'h1122_3344);
        issue("abort_sb", 1, 2'd0, 0, 9'h016, 32'h0000_00EE, 32'h0, 0, 0, 0, 0, 32'h0);
        @(negedge clock);
        @(negedge clock);
        chk("abort_in_cap", {31'b0, mem_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_mem_ctl", {30'b0, mem_read, mem_write}, 32'd0);
        chk("abort_mem_addr", {25'b0, mem_address}, 32'd0);
        chk("abort_resp_ready", {30'b0, resp_valid, req_ready}, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_mem5", mem[5], 32'h1122_3344);
        issue("abort_lw5", 0, 2'd2, 0, 9'h014, 32'h0, 32'h1122_3344, 0, 3, 1, 0, 32'h0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
